// File: rtl/data_memory_op.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_op
//  Description : Word-addressed 32-bit data memory for the MEM stage.
//                Synchronous write and combinational read. A synchronous
//                active-low reset clears every word and drops a write
//                requested in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_op #(
   parameter int ADDR_W = 18,
   parameter int DEPTH  = 1024
) (
   input  logic              Clk,
   input  logic              Rst_n,
   output logic [31:0]       out,
   input  logic [ADDR_W-1:0] a,
   input  logic              ws,
   input  logic              rs,
   input  logic [31:0]       w
);

   // Index width; DEPTH is a power of two, so the low address bits select
   // the word and anything above them wraps modulo DEPTH.
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0]      mem_q [DEPTH];
   logic [IDX_W-1:0] w_index;

   assign w_index = a[IDX_W-1:0];

   // Upper address bits are deliberately ignored; fold them into a sink so
   // the intent is explicit.
   generate
      if (ADDR_W > IDX_W) begin : g_addr_hi_sink
         logic unused_addr_hi;
         assign unused_addr_hi = ^a[ADDR_W-1:IDX_W];
      end
   endgenerate

   // Array update: reset wins over a write on the same edge.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'h0000_0000;
         end
      end else if (ws) begin
         mem_q[w_index] <= w;
      end
   end

   // Combinational read, gated to zero when the read strobe is low. The
   // write data is not bypassed: a same-cycle read shows the old word.
   always_comb begin
      out = 32'h0000_0000;
      if (rs) begin
         out = mem_q[w_index];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_op.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_op
//  Description : Self-checking bench for data_memory_op: directed vector
//                table, hand-written corner sequences and randomized traffic
//                against a behavioural array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_op;

   localparam int ADDR_W = 18;
   localparam int DEPTH  = 1024;

   logic              Clk;
   logic              Rst_n;
   logic [31:0]       out;
   logic [ADDR_W-1:0] a;
   logic              ws;
   logic              rs;
   logic [31:0]       w;

   int checks   = 0;
   int failures = 0;

   data_memory_op #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .out   (out),
      .a     (a),
      .ws    (ws),
      .rs    (rs),
      .w     (w)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Behavioural reference: a plain word array updated at each rising edge.
   logic [31:0] ref_mem [DEPTH];
   logic        ref_valid = 1'b0;

   always @(posedge Clk) begin
      if (!Rst_n) begin
         for (int i = 0; i < DEPTH; i++) ref_mem[i] <= 32'h0;
         ref_valid <= 1'b1;
      end else if (ws) begin
         ref_mem[int'(a) % DEPTH] <= w;
      end
   end

   function automatic logic [31:0] model_out();
      return rs ? ref_mem[int'(a) % DEPTH] : 32'h0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (a=%h rs=%b ws=%b t=%0t)",
                  name, act, exp, a, rs, ws, $time);
      end
   endtask

   typedef struct {
      string       name;
      logic        rst_n;
      logic        ws;
      logic        rs;
      logic [17:0] a;
      logic [31:0] w;
      logic        chk_pre;
      logic [31:0] exp_pre;
      logic [31:0] exp_post;
   } vec_t;

   vec_t vecs[13];

   initial begin
      vecs[0]  = '{"rst_edge1",   1'b0, 1'b1, 1'b1, 18'h00005, 32'hDEADBEEF, 1'b0, 32'h0,        32'h0};
      vecs[1]  = '{"rst_edge2",   1'b0, 1'b1, 1'b1, 18'h00005, 32'hDEADBEEF, 1'b1, 32'h0,        32'h0};
      vecs[2]  = '{"rst_dropwr",  1'b1, 1'b0, 1'b1, 18'h00005, 32'h0,        1'b1, 32'h0,        32'h0};
      vecs[3]  = '{"wr_a1",       1'b1, 1'b1, 1'b0, 18'h00001, 32'h12153524, 1'b1, 32'h0,        32'h0};
      vecs[4]  = '{"rd_a1",       1'b1, 1'b0, 1'b1, 18'h00001, 32'h0,        1'b1, 32'h12153524, 32'h12153524};
      vecs[5]  = '{"rs_low_zero", 1'b1, 1'b0, 1'b0, 18'h00001, 32'h0,        1'b1, 32'h0,        32'h0};
      vecs[6]  = '{"wr_a3",       1'b1, 1'b1, 1'b0, 18'h00003, 32'h11111111, 1'b1, 32'h0,        32'h0};
      vecs[7]  = '{"rdwr_a3",     1'b1, 1'b1, 1'b1, 18'h00003, 32'h22222222, 1'b1, 32'h11111111, 32'h22222222};
      vecs[8]  = '{"wr_wrap401",  1'b1, 1'b1, 1'b0, 18'h00401, 32'hCAFEF00D, 1'b1, 32'h0,        32'h0};
      vecs[9]  = '{"rd_wrap_a1",  1'b1, 1'b0, 1'b1, 18'h00001, 32'h0,        1'b1, 32'hCAFEF00D, 32'hCAFEF00D};
      vecs[10] = '{"rd_a2_clean", 1'b1, 1'b0, 1'b1, 18'h00002, 32'h0,        1'b1, 32'h0,        32'h0};
      vecs[11] = '{"rd_wrap403",  1'b1, 1'b0, 1'b1, 18'h3FC03, 32'h0,        1'b1, 32'h22222222, 32'h22222222};
      vecs[12] = '{"wr_off_rd",   1'b1, 1'b0, 1'b1, 18'h00003, 32'h55555555, 1'b1, 32'h22222222, 32'h22222222};

      // Directed table: inputs applied between edges, checked before and
      // after the following rising edge.
      for (int i = 0; i < 13; i++) begin
         Rst_n = vecs[i].rst_n;
         ws    = vecs[i].ws;
         rs    = vecs[i].rs;
         a     = vecs[i].a;
         w     = vecs[i].w;
         #1;
         if (vecs[i].chk_pre) check({vecs[i].name, "_pre"}, out, vecs[i].exp_pre);
         @(posedge Clk); #1;
         check({vecs[i].name, "_post"}, out, vecs[i].exp_post);
      end

      // Alternating strobes at a fixed address, changing every half period.
      a = 18'h00001;
      for (int k = 0; k < 6; k++) begin
         @(Clk); #1;
         rs = (k % 2) == 0;
         ws = (k % 4) < 2;
         w  = $urandom;
         #1;
         check("alt_strobe", out, model_out());
      end
      @(posedge Clk); #1;
      ws = 1'b0; rs = 1'b1; #1;
      check("alt_strobe_final", out, ref_mem[1]);

      // Isolation: eight distinct words, then read them all back.
      rs = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ws = 1'b1; a = 18'(i); w = 32'hA5000000 | 32'(i * 17);
         @(posedge Clk); #1;
      end
      ws = 1'b0; rs = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a = 18'(i); #1;
         check("isolation", out, 32'hA5000000 | 32'(i * 17));
      end

      // Randomized traffic with occasional mid-run resets.
      for (int n = 0; n < 400; n++) begin
         Rst_n = ($urandom_range(0, 39) != 0);
         ws    = $urandom_range(0, 1) == 1;
         rs    = $urandom_range(0, 2) != 0;
         a     = 18'($urandom_range(0, 15)) | (18'($urandom_range(0, 3)) << 10);
         w     = $urandom;
         #1;
         if (ref_valid) check("rand_pre", out, model_out());
         @(posedge Clk); #1;
         if (ref_valid) check("rand_post", out, model_out());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
